// File: rtl/pdp8_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// pdp8_mem_responder_pkg
//   Shared widths, request/grant types and small helpers for the PDP-8 memory
//   responder and its RAM array.
//
//   Contents:
//     ADDR_WIDTH / DATA_WIDTH  word address and word width (12 / 12)
//     MEM_DEPTH                number of words, always 2**ADDR_WIDTH
//     mem_req_s                one memory request: valid, address, write data
//     mem_gnt_e                which requester owns the array this cycle
//     hold_state_e             state of a per-port hold register
//     P_EXEC_WR/P_EXEC_RD/P_IFU_RD  indices of the three held ports
//     gnt_is_write()           true for grants that write the array
// -----------------------------------------------------------------------------
package pdp8_mem_responder_pkg;

    localparam int ADDR_WIDTH = 12;
    localparam int DATA_WIDTH = 12;
    localparam int MEM_DEPTH  = 1 << ADDR_WIDTH;

    // Indices into the per-port hold arrays. The load port never waits,
    // so it has no hold register.
    localparam int P_EXEC_WR = 0;
    localparam int P_EXEC_RD = 1;
    localparam int P_IFU_RD  = 2;
    localparam int N_PORTS   = 3;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } mem_req_s;

    typedef enum logic [2:0] {
        GNT_NONE,
        GNT_LOAD,
        GNT_EXEC_WR,
        GNT_EXEC_RD,
        GNT_IFU_RD
    } mem_gnt_e;

    typedef enum logic {
        HOLD_EMPTY,
        HOLD_HELD
    } hold_state_e;

    function automatic logic gnt_is_write(input mem_gnt_e gnt);
        return (gnt == GNT_LOAD) || (gnt == GNT_EXEC_WR);
    endfunction

endpackage

// File: rtl/pdp8_mem_responder_array.sv
// -----------------------------------------------------------------------------
// pdp8_mem_responder_array
//   Single-port synchronous 4K x 12 RAM. At most one access per clock: a write
//   when i_we=1, otherwise a read whose data is registered into o_rdata. The
//   read register only changes on a read, so it keeps the last read word.
//   The storage has no reset; contents survive reset_n.
//
//   Ports:
//     clk      in   clock, all state on posedge
//     i_en     in   access enable for this cycle
//     i_we     in   1 = write, 0 = read (qualified by i_en)
//     i_addr   in   word address
//     i_wdata  in   write data
//     o_rdata  out  registered read data
// -----------------------------------------------------------------------------
module pdp8_mem_responder_array
    import pdp8_mem_responder_pkg::*;
(
    input  logic                  clk,
    input  logic                  i_en,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // No bypass: a write cycle never updates the read register.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/pdp8_mem_responder.sv
// -----------------------------------------------------------------------------
// pdp8_mem_responder
//   Memory-side responder for the PDP-8 fetch (IFU) and execute (EXEC) memory
//   interfaces. One single-port 4K x 12 array serves IFU reads, EXEC reads,
//   EXEC writes and a preload port, one access per cycle, with fixed priority
//   load > exec_wr > exec_rd > ifu_rd.
//
//   Handshake: every request is a single-cycle pulse sampled at the rising
//   edge; there is no ready. A request that loses arbitration is parked in its
//   port's one-entry hold register and retried automatically; mem_stall is high
//   while any hold register is full so the CPU issues nothing new. A new pulse
//   on a port whose hold register is full and not granted is dropped and sets
//   the sticky err_overrun. Reads return data one cycle after their grant edge
//   with a one-cycle *_rd_valid pulse; writes pulse exec_wr_done one cycle
//   after the edge that updated the array. Read data holds its last value while
//   valid is low.
//
//   Ports:
//     clk, reset_n                         clock, async active-low reset
//     ifu_rd_req/addr -> ifu_rd_data/valid IFU read port
//     exec_rd_req/addr -> exec_rd_data/valid EXEC read port
//     exec_wr_req/addr/data -> exec_wr_done EXEC write port
//     mem_stall                            OR of hold-register full flags
//     load_en/addr/data                    preload write, highest priority,
//                                          honoured even during reset
//     err_overrun                          sticky overrun flag
// -----------------------------------------------------------------------------
module pdp8_mem_responder
    import pdp8_mem_responder_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ifu_rd_req,
    input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
    output logic [DATA_WIDTH-1:0] ifu_rd_data,
    output logic                  ifu_rd_valid,
    input  logic                  exec_rd_req,
    input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
    output logic [DATA_WIDTH-1:0] exec_rd_data,
    output logic                  exec_rd_valid,
    input  logic                  exec_wr_req,
    input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
    input  logic [DATA_WIDTH-1:0] exec_wr_data,
    output logic                  exec_wr_done,
    output logic                  mem_stall,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  err_overrun
);

    // Hold registers, one per port, each a two-state FSM.
    hold_state_e           r_hold_state [N_PORTS];
    logic [ADDR_WIDTH-1:0] r_hold_addr  [N_PORTS];
    logic [DATA_WIDTH-1:0] r_hold_data  [N_PORTS];
    logic                  r_err_overrun;

    // Response registers.
    logic                  r_ifu_rd_valid;
    logic                  r_exec_rd_valid;
    logic                  r_exec_wr_done;
    logic [DATA_WIDTH-1:0] r_ifu_rd_last;
    logic [DATA_WIDTH-1:0] r_exec_rd_last;

    mem_req_s              w_new  [N_PORTS];
    mem_req_s              w_cand [N_PORTS];
    mem_req_s              w_sel;
    mem_gnt_e              w_gnt;
    logic [N_PORTS-1:0]    w_port_gnt;
    logic [N_PORTS-1:0]    w_held;
    logic [DATA_WIDTH-1:0] w_rdata;

    // Candidate per port: the parked request wins over a new pulse so that
    // requests on one port are served in arrival order.
    always_comb begin
        w_new[P_EXEC_WR] = '{valid: exec_wr_req, addr: exec_wr_addr, data: exec_wr_data};
        w_new[P_EXEC_RD] = '{valid: exec_rd_req, addr: exec_rd_addr, data: '0};
        w_new[P_IFU_RD]  = '{valid: ifu_rd_req,  addr: ifu_rd_addr,  data: '0};
        for (int p = 0; p < N_PORTS; p++) begin
            w_held[p] = (r_hold_state[p] == HOLD_HELD);
            if (w_held[p]) begin
                w_cand[p] = '{valid: 1'b1, addr: r_hold_addr[p], data: r_hold_data[p]};
            end else begin
                w_cand[p] = w_new[p];
            end
        end
    end

    // Fixed-priority arbiter. Granting writes ahead of reads keeps any write
    // that is pending alongside a read to the same address visible to it.
    always_comb begin
        w_gnt = GNT_NONE;
        w_sel = '0;
        if (load_en) begin
            w_gnt = GNT_LOAD;
            w_sel = '{valid: 1'b1, addr: load_addr, data: load_data};
        end else if (w_cand[P_EXEC_WR].valid) begin
            w_gnt = GNT_EXEC_WR;
            w_sel = w_cand[P_EXEC_WR];
        end else if (w_cand[P_EXEC_RD].valid) begin
            w_gnt = GNT_EXEC_RD;
            w_sel = w_cand[P_EXEC_RD];
        end else if (w_cand[P_IFU_RD].valid) begin
            w_gnt = GNT_IFU_RD;
            w_sel = w_cand[P_IFU_RD];
        end
        w_port_gnt            = '0;
        w_port_gnt[P_EXEC_WR] = (w_gnt == GNT_EXEC_WR);
        w_port_gnt[P_EXEC_RD] = (w_gnt == GNT_EXEC_RD);
        w_port_gnt[P_IFU_RD]  = (w_gnt == GNT_IFU_RD);
    end

    // The array itself is not reset, so a preload during reset still lands.
    pdp8_mem_responder_array u_array (
        .clk     (clk),
        .i_en    (w_sel.valid),
        .i_we    (gnt_is_write(w_gnt)),
        .i_addr  (w_sel.addr),
        .i_wdata (w_sel.data),
        .o_rdata (w_rdata)
    );

    // Hold-register FSMs and the sticky overrun flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < N_PORTS; p++) begin
                r_hold_state[p] <= HOLD_EMPTY;
                r_hold_addr[p]  <= '0;
                r_hold_data[p]  <= '0;
            end
            r_err_overrun <= 1'b0;
        end else begin
            for (int p = 0; p < N_PORTS; p++) begin
                case (r_hold_state[p])
                    HOLD_EMPTY: begin
                        if (w_new[p].valid && !w_port_gnt[p]) begin
                            r_hold_state[p] <= HOLD_HELD;
                            r_hold_addr[p]  <= w_new[p].addr;
                            r_hold_data[p]  <= w_new[p].data;
                        end
                    end
                    HOLD_HELD: begin
                        if (w_port_gnt[p]) begin
                            // The entry leaves this edge; a pulse arriving in
                            // the same cycle takes the freed slot.
                            if (w_new[p].valid) begin
                                r_hold_addr[p] <= w_new[p].addr;
                                r_hold_data[p] <= w_new[p].data;
                            end else begin
                                r_hold_state[p] <= HOLD_EMPTY;
                            end
                        end else if (w_new[p].valid) begin
                            r_err_overrun <= 1'b1;
                        end
                    end
                    default: r_hold_state[p] <= HOLD_EMPTY;
                endcase
            end
        end
    end

    // Response pulses and last-value registers for the read data outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ifu_rd_valid  <= 1'b0;
            r_exec_rd_valid <= 1'b0;
            r_exec_wr_done  <= 1'b0;
            r_ifu_rd_last   <= '0;
            r_exec_rd_last  <= '0;
        end else begin
            r_ifu_rd_valid  <= (w_gnt == GNT_IFU_RD);
            r_exec_rd_valid <= (w_gnt == GNT_EXEC_RD);
            r_exec_wr_done  <= (w_gnt == GNT_EXEC_WR);
            if (r_ifu_rd_valid) begin
                r_ifu_rd_last <= w_rdata;
            end
            if (r_exec_rd_valid) begin
                r_exec_rd_last <= w_rdata;
            end
        end
    end

    // The array read register is shared, so each port shows it only during
    // its own valid cycle and its private copy afterwards.
    assign ifu_rd_data   = r_ifu_rd_valid  ? w_rdata : r_ifu_rd_last;
    assign exec_rd_data  = r_exec_rd_valid ? w_rdata : r_exec_rd_last;
    assign ifu_rd_valid  = r_ifu_rd_valid;
    assign exec_rd_valid = r_exec_rd_valid;
    assign exec_wr_done  = r_exec_wr_done;
    assign mem_stall     = |w_held;
    assign err_overrun   = r_err_overrun;

endmodule

// File: tb/tb_pdp8_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_pdp8_mem_responder
//   Directed bench for pdp8_mem_responder. Inputs change 1 time unit after the
//   rising edge; outputs are checked in the same window, away from the edge.
// -----------------------------------------------------------------------------
module tb_pdp8_mem_responder;

    logic        clk;
    logic        reset_n;
    logic        ifu_rd_req;
    logic [11:0] ifu_rd_addr;
    logic [11:0] ifu_rd_data;
    logic        ifu_rd_valid;
    logic        exec_rd_req;
    logic [11:0] exec_rd_addr;
    logic [11:0] exec_rd_data;
    logic        exec_rd_valid;
    logic        exec_wr_req;
    logic [11:0] exec_wr_addr;
    logic [11:0] exec_wr_data;
    logic        exec_wr_done;
    logic        mem_stall;
    logic        load_en;
    logic [11:0] load_addr;
    logic [11:0] load_data;
    logic        err_overrun;

    int n_checks = 0;
    int n_pass   = 0;

    pdp8_mem_responder dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ifu_rd_req    (ifu_rd_req),
        .ifu_rd_addr   (ifu_rd_addr),
        .ifu_rd_data   (ifu_rd_data),
        .ifu_rd_valid  (ifu_rd_valid),
        .exec_rd_req   (exec_rd_req),
        .exec_rd_addr  (exec_rd_addr),
        .exec_rd_data  (exec_rd_data),
        .exec_rd_valid (exec_rd_valid),
        .exec_wr_req   (exec_wr_req),
        .exec_wr_addr  (exec_wr_addr),
        .exec_wr_data  (exec_wr_data),
        .exec_wr_done  (exec_wr_done),
        .mem_stall     (mem_stall),
        .load_en       (load_en),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .err_overrun   (err_overrun)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0o expected %0o", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        ifu_rd_req  = 1'b0;
        exec_rd_req = 1'b0;
        exec_wr_req = 1'b0;
        load_en     = 1'b0;
    endtask

    task automatic load(input logic [11:0] a, input logic [11:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        step();
        load_en   = 1'b0;
    endtask

    task automatic drive_wr(input logic [11:0] a, input logic [11:0] d);
        exec_wr_req  = 1'b1;
        exec_wr_addr = a;
        exec_wr_data = d;
    endtask

    task automatic drive_rd(input logic [11:0] a);
        exec_rd_req  = 1'b1;
        exec_rd_addr = a;
    endtask

    task automatic drive_ifu(input logic [11:0] a);
        ifu_rd_req  = 1'b1;
        ifu_rd_addr = a;
    endtask

    initial begin
        reset_n      = 1'b0;
        clear_reqs();
        ifu_rd_addr  = '0;
        exec_rd_addr = '0;
        exec_wr_addr = '0;
        exec_wr_data = '0;
        load_addr    = '0;
        load_data    = '0;

        // Reset state
        step();
        step();
        check("rst_ifu_valid",  ifu_rd_valid,  0);
        check("rst_exec_valid", exec_rd_valid, 0);
        check("rst_wr_done",    exec_wr_done,  0);
        check("rst_stall",      mem_stall,     0);
        check("rst_overrun",    err_overrun,   0);
        check("rst_ifu_data",   ifu_rd_data,   0);
        check("rst_exec_data",  exec_rd_data,  0);
        reset_n = 1'b1;
        step();

        // 1: preload and single IFU fetch, latency 1
        load(12'o0000, 12'o0123);
        load(12'o0200, 12'o7200);
        drive_ifu(12'o0200);
        step();
        clear_reqs();
        check("t1_ifu_valid", ifu_rd_valid, 1);
        check("t1_ifu_data",  ifu_rd_data,  12'o7200);
        check("t1_stall",     mem_stall,    0);
        step();
        check("t1_valid_drop", ifu_rd_valid, 0);
        check("t1_data_hold",  ifu_rd_data,  12'o7200);

        // 2: write and IFU read to the same address in one cycle
        drive_wr(12'o0300, 12'o1234);
        drive_ifu(12'o0300);
        step();
        clear_reqs();
        check("t2_done",       exec_wr_done, 1);
        check("t2_stall",      mem_stall,    1);
        check("t2_ifu_wait",   ifu_rd_valid, 0);
        step();
        check("t2_done_drop",  exec_wr_done, 0);
        check("t2_stall_drop", mem_stall,    0);
        check("t2_ifu_valid",  ifu_rd_valid, 1);
        check("t2_ifu_data",   ifu_rd_data,  12'o1234);

        // 3: all three ports at once, exec_rd reads the just-written word
        drive_wr(12'o0400, 12'o4321);
        drive_rd(12'o0400);
        drive_ifu(12'o0200);
        step();
        clear_reqs();
        check("t3_c1_done",   exec_wr_done,  1);
        check("t3_c1_stall",  mem_stall,     1);
        check("t3_c1_rd",     exec_rd_valid, 0);
        check("t3_c1_ifu",    ifu_rd_valid,  0);
        step();
        check("t3_c2_done",   exec_wr_done,  0);
        check("t3_c2_rd",     exec_rd_valid, 1);
        check("t3_c2_rdata",  exec_rd_data,  12'o4321);
        check("t3_c2_stall",  mem_stall,     1);
        check("t3_c2_ifu",    ifu_rd_valid,  0);
        step();
        check("t3_c3_rd",     exec_rd_valid, 0);
        check("t3_c3_ifu",    ifu_rd_valid,  1);
        check("t3_c3_idata",  ifu_rd_data,   12'o7200);
        check("t3_c3_stall",  mem_stall,     0);

        // 4: second IFU pulse while the first is still held
        drive_wr(12'o0500, 12'o0055);
        drive_rd(12'o0400);
        drive_ifu(12'o0500);
        step();
        clear_reqs();
        check("t4_stall", mem_stall, 1);
        drive_ifu(12'o0200);
        step();
        clear_reqs();
        check("t4_overrun",   err_overrun,   1);
        check("t4_rd_valid",  exec_rd_valid, 1);
        check("t4_rd_data",   exec_rd_data,  12'o4321);
        check("t4_stall2",    mem_stall,     1);
        step();
        check("t4_ifu_valid", ifu_rd_valid,  1);
        check("t4_ifu_data",  ifu_rd_data,   12'o0055);
        check("t4_stall_end", mem_stall,     0);
        step();
        check("t4_no_extra",  ifu_rd_valid,  0);
        check("t4_sticky",    err_overrun,   1);

        // 5: reset while entries are held; preload during reset
        load(12'o0600, 12'o3333);
        drive_wr(12'o0700, 12'o1111);
        drive_rd(12'o0600);
        drive_ifu(12'o0600);
        step();
        clear_reqs();
        check("t5_pre_stall", mem_stall,    1);
        check("t5_pre_done",  exec_wr_done, 1);
        #1;
        reset_n = 1'b0;
        #1;
        check("t5_rst_stall",   mem_stall,     0);
        check("t5_rst_done",    exec_wr_done,  0);
        check("t5_rst_rd",      exec_rd_valid, 0);
        check("t5_rst_ifu",     ifu_rd_valid,  0);
        check("t5_rst_overrun", err_overrun,   0);
        @(posedge clk);
        #1;
        load(12'o0650, 12'o2222);
        reset_n = 1'b1;
        step();
        check("t5_drop_rd",    exec_rd_valid, 0);
        check("t5_drop_ifu",   ifu_rd_valid,  0);
        check("t5_drop_stall", mem_stall,     0);
        drive_rd(12'o0600);
        drive_ifu(12'o0650);
        step();
        clear_reqs();
        check("t5_rd_valid",  exec_rd_valid, 1);
        check("t5_rd_data",   exec_rd_data,  12'o3333);
        step();
        check("t5_ifu_valid", ifu_rd_valid,  1);
        check("t5_ifu_data",  ifu_rd_data,   12'o2222);
        drive_rd(12'o0700);
        step();
        clear_reqs();
        check("t5_wr_kept", exec_rd_data, 12'o1111);

        // 6: top address, and no aliasing onto address 0
        drive_wr(12'o7777, 12'o5555);
        step();
        clear_reqs();
        check("t6_done", exec_wr_done, 1);
        drive_rd(12'o7777);
        step();
        clear_reqs();
        check("t6_rd_valid", exec_rd_valid, 1);
        check("t6_rd_top",   exec_rd_data,  12'o5555);
        drive_rd(12'o0000);
        step();
        clear_reqs();
        check("t6_rd_zero",  exec_rd_data,  12'o0123);
        step();
        check("t6_hold",     exec_rd_data,  12'o0123);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
